// File: rtl/conv_window_scheduler_if.sv
// Signal bundle between the window scheduler and its surroundings:
// start/status, the image-memory read port, the dot-product engine
// handshake and the output feature-map write port.
interface conv_window_scheduler_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              img_rd_en;
    logic [ADDR_W-1:0] img_addr;
    logic [31:0]       img_rd_data;
    logic [287:0]      win_data;
    logic              dot_start;
    logic              dot_ready;
    logic [31:0]       dot_result;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;

    // The scheduler side.
    modport master (
        input  start, img_rd_data, dot_ready, dot_result,
        output busy, done, err, img_rd_en, img_addr, win_data,
               dot_start, out_we, out_addr, out_data
    );

    // The memories / engine / controller side.
    modport slave (
        output start, img_rd_data, dot_ready, dot_result,
        input  busy, done, err, img_rd_en, img_addr, win_data,
               dot_start, out_we, out_addr, out_data
    );
endinterface

// File: rtl/conv_window_scheduler.sv
// Walks every valid 3x3 window of an IMG_W x IMG_H image (stride 1, no
// padding) in row-major order: fetches the nine pixels, hands them to the
// dot-product engine with a level start, waits for its result (with a
// timeout), writes the result to the output map and completes a four-phase
// release before moving on.
module conv_window_scheduler #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_window_scheduler_if.master bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 3);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 3);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMPUTE,
        WRITE,
        RELEASE,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [3:0]    k_q, k_d;
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
    logic [287:0]  win_q, win_d;
    logic [31:0]   res_q, res_d;

    logic [1:0]        kRow, kCol;
    logic [ADDR_W-1:0] fetchAddr;
    logic [ADDR_W-1:0] outAddr;

    // Split the fetch index into its row and column offset inside the window.
    always_comb begin
        kRow = 2'd0;
        kCol = 2'd0;
        case (k_q)
            4'd1:    begin kRow = 2'd0; kCol = 2'd1; end
            4'd2:    begin kRow = 2'd0; kCol = 2'd2; end
            4'd3:    begin kRow = 2'd1; kCol = 2'd0; end
            4'd4:    begin kRow = 2'd1; kCol = 2'd1; end
            4'd5:    begin kRow = 2'd1; kCol = 2'd2; end
            4'd6:    begin kRow = 2'd2; kCol = 2'd0; end
            4'd7:    begin kRow = 2'd2; kCol = 2'd1; end
            4'd8:    begin kRow = 2'd2; kCol = 2'd2; end
            default: begin kRow = 2'd0; kCol = 2'd0; end
        endcase
    end

    assign fetchAddr = (ADDR_W'(r_q) + ADDR_W'(kRow)) * ADDR_W'(IMG_W)
                     + ADDR_W'(c_q) + ADDR_W'(kCol);
    assign outAddr   = ADDR_W'(r_q) * ADDR_W'(IMG_W - 2) + ADDR_W'(c_q);

    assign bus.err      = err_q;
    assign bus.win_data = win_q;
    assign bus.out_data = res_q;

    // Next-state and strobe decode; every strobe is derived from the current
    // state so an asynchronous reset clears them immediately.
    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        c_d           = c_q;
        k_d           = k_q;
        to_d          = to_q;
        err_d         = err_q;
        win_d         = win_q;
        res_d         = res_q;
        bus.busy      = (state_q != IDLE);
        bus.done      = 1'b0;
        bus.img_rd_en = 1'b0;
        bus.img_addr  = '0;
        bus.dot_start = 1'b0;
        bus.out_we    = 1'b0;
        bus.out_addr  = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    to_d    = '0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (k_q != 4'd9) begin
                    bus.img_rd_en = 1'b1;
                    bus.img_addr  = fetchAddr;
                end
                for (int s = 0; s < 9; s++) begin
                    if (k_q == 4'(s + 1)) begin
                        win_d[32*s +: 32] = bus.img_rd_data;
                    end
                end
                if (k_q == 4'd9) begin
                    to_d    = '0;
                    state_d = COMPUTE;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            COMPUTE: begin
                bus.dot_start = 1'b1;
                if (bus.dot_ready) begin
                    res_d   = bus.dot_result;
                    state_d = WRITE;
                end else if (to_q == TO_MAX) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = WRITE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WRITE: begin
                bus.out_we   = 1'b1;
                bus.out_addr = outAddr;
                state_d      = RELEASE;
            end
            RELEASE: begin
                if (!bus.dot_ready) begin
                    k_d = '0;
                    if (r_q == LAST_R && c_q == LAST_C) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        if (c_q == LAST_C) begin
                            c_d = '0;
                            r_d = r_q + 1'b1;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, window position, fetch/timeout counters and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            win_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            to_q    <= to_d;
            err_q   <= err_d;
            win_q   <= win_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench: a 4x4 instance (TIMEOUT=20) with an image memory,
// a configurable summing engine stub and write/read monitors, plus a 3x3
// instance for the single-window case.
module tb_conv_window_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    conv_window_scheduler_if #(.ADDR_W(16)) aIf ();
    conv_window_scheduler_if #(.ADDR_W(16)) bIf ();

    conv_window_scheduler #(.IMG_W(4), .IMG_H(4), .ADDR_W(16), .TIMEOUT(20)) dutA (
        .clk(clk),
        .rst(rst),
        .bus(aIf)
    );

    conv_window_scheduler #(.IMG_W(3), .IMG_H(3), .ADDR_W(16), .TIMEOUT(20)) dutB (
        .clk(clk),
        .rst(rst),
        .bus(bIf)
    );

    typedef struct packed {
        int               lat;
        int               hold;
        bit               never;
        logic [3:0][31:0] exp;
        bit               expErr;
    } vec_t;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    // Image memories, one-cycle read latency.
    logic [31:0] aMem [16];
    logic [31:0] bMem [9];
    logic [31:0] aRd = '0;
    logic [31:0] bRd = '0;

    // Engine stub knobs and state.
    int          aLat = 5;
    int          aHold = 0;
    bit          aNever = 1'b0;
    int          aCnt = 0;
    int          aHoldCnt = 0;
    logic        aReady = 1'b0;
    logic [31:0] aResult = '0;
    int          bLat = 3;
    int          bCnt = 0;
    logic        bReady = 1'b0;
    logic [31:0] bResult = '0;

    // Monitor logs.
    logic [15:0] rdAddrQ [$];
    int          rdCycQ [$];
    logic [15:0] wrAddrQ [$];
    logic [31:0] wrDataQ [$];
    int          wrCycQ [$];
    int          doneCount = 0;
    int          doneCyc = 0;
    int          readWhileReady = 0;
    logic [15:0] bWrAddrQ [$];
    logic [31:0] bWrDataQ [$];
    int          bWrCycQ [$];
    int          bDoneCount = 0;
    int          bDoneCyc = 0;

    assign aIf.img_rd_data = aRd;
    assign aIf.dot_ready   = aReady;
    assign aIf.dot_result  = aResult;
    assign bIf.img_rd_data = bRd;
    assign bIf.dot_ready   = bReady;
    assign bIf.dot_result  = bResult;

    function automatic logic [31:0] windowSum(input logic [287:0] w);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s = s + w[32*k +: 32];
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Image memory read ports.
    always @(posedge clk) begin
        if (aIf.img_rd_en) aRd <= aMem[aIf.img_addr[3:0]];
        if (bIf.img_rd_en) bRd <= bMem[bIf.img_addr[3:0] % 9];
    end

    // Engine stub A: ready after aLat cycles of dot_start, held aHold extra cycles after release.
    always @(posedge clk) begin
        if (aIf.dot_start && !aNever) begin
            aHoldCnt <= aHold;
            if (aCnt >= aLat) begin
                aReady  <= 1'b1;
                aResult <= windowSum(aIf.win_data);
            end else begin
                aCnt <= aCnt + 1;
            end
        end else begin
            aCnt <= 0;
            if (aReady) begin
                if (aHoldCnt == 0) aReady <= 1'b0;
                else aHoldCnt <= aHoldCnt - 1;
            end
        end
    end

    // Engine stub B: plain four-phase responder.
    always @(posedge clk) begin
        if (bIf.dot_start) begin
            if (bCnt >= bLat) begin
                bReady  <= 1'b1;
                bResult <= windowSum(bIf.win_data);
            end else begin
                bCnt <= bCnt + 1;
            end
        end else begin
            bCnt   <= 0;
            bReady <= 1'b0;
        end
    end

    // Log reads, writes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (aIf.img_rd_en) begin
            rdAddrQ.push_back(aIf.img_addr);
            rdCycQ.push_back(cyc);
            if (aIf.dot_ready) readWhileReady++;
        end
        if (aIf.out_we) begin
            wrAddrQ.push_back(aIf.out_addr);
            wrDataQ.push_back(aIf.out_data);
            wrCycQ.push_back(cyc);
        end
        if (aIf.done) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (bIf.out_we) begin
            bWrAddrQ.push_back(bIf.out_addr);
            bWrDataQ.push_back(bIf.out_data);
            bWrCycQ.push_back(cyc);
        end
        if (bIf.done) begin
            bDoneCount++;
            bDoneCyc = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int lat, input int hold, input bit never);
        aLat   = lat;
        aHold  = hold;
        aNever = never;
        rdAddrQ.delete();
        rdCycQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycQ.delete();
        doneCount      = 0;
        readWhileReady = 0;
        @(negedge clk);
        aIf.start = 1'b1;
        @(negedge clk);
        aIf.start = 1'b0;
    endtask

    task automatic waitDoneA(input string name);
        int n;
        n = 0;
        while (doneCount == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " done within budget"}, (n < 3000), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic checkImage(input string name, input logic [3:0][31:0] exp, input bit expErr, input int hold);
        checkOutput({name, " write count"}, wrDataQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wrDataQ.size()) begin
                checkOutput($sformatf("%s wr%0d addr", name, i), wrAddrQ[i], i);
                checkOutput($sformatf("%s wr%0d data", name, i), wrDataQ[i], exp[i]);
            end
        end
        checkOutput({name, " err"}, aIf.err, expErr);
        checkOutput({name, " done pulses"}, doneCount, 1);
        checkOutput({name, " busy after done"}, aIf.busy, 0);
        checkOutput({name, " reads during ready"}, readWhileReady, 0);
        if (wrCycQ.size() > 0)
            checkOutput({name, " done after release"}, doneCyc - wrCycQ[wrCycQ.size()-1], 2 + hold);
    endtask

    task automatic checkFetchOrder(input string name);
        int fexp [9];
        fexp = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        checkOutput({name, " read count"}, rdAddrQ.size(), 36);
        if (rdAddrQ.size() >= 18) begin
            for (int i = 0; i < 9; i++) begin
                checkOutput($sformatf("%s win01 fetch%0d addr", name, i), rdAddrQ[9+i], fexp[i]);
                if (i > 0)
                    checkOutput($sformatf("%s win01 fetch%0d gap", name, i), rdCycQ[9+i] - rdCycQ[8+i], 1);
            end
        end
    endtask

    task automatic checkResetA(input string name);
        checkOutput({name, " busy"}, aIf.busy, 0);
        checkOutput({name, " done"}, aIf.done, 0);
        checkOutput({name, " err"}, aIf.err, 0);
        checkOutput({name, " img_rd_en"}, aIf.img_rd_en, 0);
        checkOutput({name, " img_addr"}, aIf.img_addr, 0);
        checkOutput({name, " win_data zero"}, (aIf.win_data == '0), 1);
        checkOutput({name, " dot_start"}, aIf.dot_start, 0);
        checkOutput({name, " out_we"}, aIf.out_we, 0);
        checkOutput({name, " out_addr"}, aIf.out_addr, 0);
        checkOutput({name, " out_data"}, aIf.out_data, 0);
    endtask

    // Abort guard in case something stalls outside the bounded waits.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: time limit reached, %0d tests run", testsRun);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t             vecs [5];
        logic [3:0][31:0] expA;
        logic [31:0]      s;
        int               n;
        int               lat;
        int               hold;

        vecs[0] = '{lat: 5,  hold: 0, never: 1'b0, exp: {32'd90, 32'd81, 32'd54, 32'd45}, expErr: 1'b0};
        vecs[1] = '{lat: 0,  hold: 0, never: 1'b0, exp: {32'd90, 32'd81, 32'd54, 32'd45}, expErr: 1'b0};
        vecs[2] = '{lat: 12, hold: 3, never: 1'b0, exp: {32'd90, 32'd81, 32'd54, 32'd45}, expErr: 1'b0};
        vecs[3] = '{lat: 2,  hold: 7, never: 1'b0, exp: {32'd90, 32'd81, 32'd54, 32'd45}, expErr: 1'b0};
        vecs[4] = '{lat: 0,  hold: 0, never: 1'b1, exp: {32'd0, 32'd0, 32'd0, 32'd0},      expErr: 1'b1};

        for (int i = 0; i < 16; i++) aMem[i] = 32'(i);
        for (int i = 0; i < 9; i++) bMem[i] = 32'(i);
        aIf.start = 1'b0;
        bIf.start = 1'b0;

        #1 rst = 1'b1;
        #1 checkResetA("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetA("idle after reset");

        // Table-driven runs on the 4x4 image with pixel[i] = i.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].lat, vecs[v].hold, vecs[v].never);
            waitDoneA($sformatf("vec%0d", v));
            checkImage($sformatf("vec%0d", v), vecs[v].exp, vecs[v].expErr, vecs[v].never ? 0 : vecs[v].hold);
            checkFetchOrder($sformatf("vec%0d", v));
        end

        // err is still set from the timeout run; the next start clears it and reads at once.
        checkOutput("err sticky while idle", aIf.err, 1);
        applyStimulus(5, 0, 0);
        checkOutput("err cleared on start", aIf.err, 0);
        checkOutput("busy after start", aIf.busy, 1);
        checkOutput("first read latency", aIf.img_rd_en, 1);
        checkOutput("first read addr", aIf.img_addr, 0);
        waitDoneA("after-timeout");
        checkImage("after-timeout", vecs[0].exp, 1'b0, 0);

        // A start pulse in the middle of COMPUTE is dropped.
        applyStimulus(5, 0, 0);
        n = 0;
        while (!(wrDataQ.size() == 1 && aIf.dot_start) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy-start reached compute", (n < 500), 1);
        repeat (2) @(negedge clk);
        aIf.start = 1'b1;
        @(negedge clk);
        aIf.start = 1'b0;
        waitDoneA("busy-start");
        checkImage("busy-start", vecs[0].exp, 1'b0, 0);
        checkFetchOrder("busy-start");

        // Reset during the second window's COMPUTE.
        applyStimulus(5, 0, 0);
        n = 0;
        while (!(wrDataQ.size() == 1 && aIf.dot_start) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid-reset reached compute", (n < 500), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkResetA("mid-reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid-reset no extra write", wrDataQ.size(), 1);
        applyStimulus(5, 0, 0);
        waitDoneA("post-reset");
        checkImage("post-reset", vecs[0].exp, 1'b0, 0);
        checkFetchOrder("post-reset");
        if (rdAddrQ.size() > 0) checkOutput("post-reset first read", rdAddrQ[0], 0);

        // Randomized images and engine timing against a window-sum model.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) aMem[i] = $urandom;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    s = '0;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            s = s + aMem[(r + dr) * 4 + c + dc];
                    expA[r * 2 + c] = s;
                end
            end
            lat  = int'($urandom_range(0, 10));
            hold = int'($urandom_range(0, 4));
            applyStimulus(lat, hold, 1'b0);
            waitDoneA($sformatf("rand%0d", it));
            checkImage($sformatf("rand%0d", it), expA, 1'b0, hold);
        end

        // Single-window 3x3 image.
        for (int it = 0; it < 3; it++) begin
            s = '0;
            for (int i = 0; i < 9; i++) begin
                bMem[i] = $urandom;
                s = s + bMem[i];
            end
            bLat = int'($urandom_range(0, 8));
            bWrAddrQ.delete();
            bWrDataQ.delete();
            bWrCycQ.delete();
            bDoneCount = 0;
            @(negedge clk);
            bIf.start = 1'b1;
            @(negedge clk);
            bIf.start = 1'b0;
            n = 0;
            while (bDoneCount == 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("b%0d done within budget", it), (n < 1000), 1);
            repeat (4) @(negedge clk);
            checkOutput($sformatf("b%0d write count", it), bWrDataQ.size(), 1);
            if (bWrDataQ.size() > 0) begin
                checkOutput($sformatf("b%0d addr", it), bWrAddrQ[0], 0);
                checkOutput($sformatf("b%0d data", it), bWrDataQ[0], s);
                checkOutput($sformatf("b%0d done after release", it), bDoneCyc - bWrCycQ[0], 2);
            end
            checkOutput($sformatf("b%0d done pulses", it), bDoneCount, 1);
            checkOutput($sformatf("b%0d err", it), bIf.err, 0);
            checkOutput($sformatf("b%0d busy", it), bIf.busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequencer that drives the 3x3 floating-point dot-product engine across a whole image. On a start request it walks every valid 3x3 window (no padding, stride 1) in row-major order. For each window it fetches 9 pixels from the image memory, presents them with a level-held start to the dot-product engine, and waits for the engine's ready. It then writes the 32-bit result to the output feature-map memory. It sits between the image/feature-map RAMs and the dot-product engine; filter coefficients are wired to the engine directly and are not handled here.

## Interface
Parameters:
- IMG_W, 8, image width in pixels; legal range 3..256.
- IMG_H, 8, image height in pixels; legal range 3..256.
- ADDR_W, 16, address width of the image and output memories.
- TIMEOUT, 255, maximum cycles to wait for dot_ready before abandoning a window.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process the whole image; ignored unless in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the last window has been written.
- err  out  1  sticky timeout flag; cleared when the next start is accepted.
- img_rd_en  out  1  image memory read strobe.
- img_addr  out  ADDR_W  image read address = row*IMG_W + col.
- img_rd_data  in  32  read data, valid exactly one cycle after img_rd_en.
- win_data  out  288  window pixels; k = 0..8 occupies bits [32k+31:32k], row-major in the window.
- dot_start  out  1  level start to the engine.
- dot_ready  in  1  engine result-valid level.
- dot_result  in  32  engine result, valid while dot_ready=1.
- out_we  out  1  output memory write strobe.
- out_addr  out  ADDR_W  output address = r*(IMG_W-2) + c.
- out_data  out  32  write data.

## Operation
- States: IDLE, FETCH, COMPUTE, RELEASE, WRITE, DONE.
- Window position registers: r in 0..IMG_H-3 and c in 0..IMG_W-3. Fetch index k in 0..9. Timeout counter is sized for TIMEOUT.
- IDLE: on start=1, clear r, c, k and err, then go to FETCH.
- FETCH: for k = 0..8, assert img_rd_en with img_addr = (r+k/3)*IMG_W + (c+k%3).
  - Data returned one cycle later is stored into win_data slot k-1.
  - At k=9 no read is issued; the last word is captured and the state goes to COMPUTE.
  - FETCH lasts exactly 10 cycles.
- COMPUTE: hold dot_start=1 and increment the timeout counter.
  - When dot_ready=1 is sampled, latch dot_result into out_data, drop dot_start and go to WRITE.
  - When the counter reaches TIMEOUT with dot_ready=0, set out_data=0, set err=1, drop dot_start and go to WRITE.
- WRITE: assert out_we for one cycle with out_addr for (r,c), then go to RELEASE.
- RELEASE: keep dot_start=0 and wait until dot_ready=0 (four-phase handshake). Then advance the window position:
  - if c < IMG_W-3: c+1;
  - else c=0 and r+1;
  - if the window just written was (IMG_H-3, IMG_W-3), go to DONE;
  - otherwise go to FETCH with k=0.
- RELEASE is not timed out; a stuck-high dot_ready stalls the block there.
- DONE: pulse done for one cycle, then go to IDLE.
- win_data is held stable throughout COMPUTE; the engine may sample it at any point while dot_start=1.
- A start arriving in any state other than IDLE is dropped, with no queueing.

## Timing
- Reset values: busy=0, done=0, err=0, img_rd_en=0, img_addr=0, win_data=0, dot_start=0, out_we=0, out_addr=0, out_data=0. The state is IDLE.
- Reset asserted mid-operation returns to IDLE immediately. The engine sees dot_start fall asynchronously, and no partial write is issued after reset.
- Start-to-first-read latency: start is sampled at edge N; img_rd_en is high in the cycle after N.
- Per window: 10 cycles FETCH + (engine latency + 1) cycles COMPUTE + 1 cycle WRITE + at least 1 cycle RELEASE.
- out_we is high for one cycle per window. Total writes = (IMG_W-2)*(IMG_H-2), never more.
- For a 3x3 image there is exactly one window, and DONE follows its first WRITE/RELEASE.
- dot_ready already high on COMPUTE entry is accepted on the first COMPUTE cycle. The preceding RELEASE guarantees this is a fresh result.

## Test plan
- Use a 4x4 image with pixel[i]=i and a stub engine that returns the sum of the window after 5 cycles. Expect 4 writes: addr0=45, addr1=54, addr2=81, addr3=90. Expect done one cycle after the last RELEASE and err=0.
- Check FETCH order on window (0,1) of the 4x4 image: img_addr sequence must be 1,2,3,5,6,7,9,10,11 on consecutive cycles.
- Set TIMEOUT=20 with an engine that never raises ready. First write must be 0 at addr0, with err=1 and the sequence still completing all 4 windows. A following start must clear err.
- Pulse start while busy in the middle of COMPUTE: there must be no restart and the write count stays 4.
- Assert rst during the second window's COMPUTE: all outputs return to their reset values within the cycle. A new start then processes from window (0,0).
- Hold dot_ready high for 7 extra cycles after dot_start falls: the block must stay in RELEASE and issue no FETCH read until dot_ready=0.
